evo_pin_filter: RTL and testbench
=================================

# evo_pin_filter

Input conditioning stage between the FPGA's Feather D pins and the core logic. It sits directly downstream of the top-level pin boundary and upstream of the core. It synchronizes asynchronous pin levels into the core clock domain and applies a per-pin programmable glitch filter. It emits one-cycle rise/fall event pulses that core peripherals (pin-change interrupts, capture logic) consume.

## Interface
Parameters:
- WIDTH, 11, number of conditioned pins (D0, D1, D4, D5, D6, D8, D9, D10..D13 in bit order 0..10)
- SYNC_STAGES, 2, synchronizer flops per pin; legal range 2..4
- FILT_CNT_W, 8, width of filter length and per-pin counters

Ports:
- clk, input, 1, core clock; all state on rising edge
- rst, input, 1, reset, asynchronous and active-high; one clock, no other reset
- pin_in, input, WIDTH, raw asynchronous pin levels
- filt_en, input, WIDTH, per-pin filter enable (quasi-static, clk domain)
- filt_len, input, FILT_CNT_W, required stable cycles before a filtered pin changes (shared by all pins)
- pin_sync, output, WIDTH, synchronizer output (last stage)
- pin_filt, output, WIDTH, filtered level
- rise_pulse, output, WIDTH, one-cycle pulse when pin_filt goes 0->1
- fall_pulse, output, WIDTH, one-cycle pulse when pin_filt goes 1->0
- chg_any, output, 1, OR of all rise_pulse and fall_pulse bits, registered with them

## Operation
- Synchronizer: per pin, a chain of SYNC_STAGES flops; pin_sync is the last stage. There is no logic between stages.
- Effective threshold per pin: T = 1 if filt_en[i]==0 or filt_len==0, else T = filt_len.
- Per-pin counter cnt[i] (FILT_CNT_W bits):
  - pin_sync[i]==pin_filt[i]: cnt <= 0.
  - pin_sync[i]!=pin_filt[i] and cnt+1 >= T: pin_filt[i] <= pin_sync[i], cnt <= 0, update strobe.
  - Otherwise: cnt <= cnt+1.
- The compare is >= (not ==). Lowering filt_len or clearing filt_en mid-count therefore updates on the next differing cycle. cnt never exceeds 2^FILT_CNT_W-2, so there is no wrap.
- A single-cycle return to equality (glitch) clears cnt. The count restarts from 0 on the next difference.
- rise_pulse[i] <= update & pin_sync[i]; fall_pulse[i] <= update & ~pin_sync[i]. Both deassert the following cycle unless a new update occurs. Pulses are mutually exclusive per pin.
- chg_any <= |(next rise_pulse | next fall_pulse), so it is coincident with the pulses.
- Pins are fully independent. Simultaneous updates on several pins all pulse in the same cycle.
- Reset values (asynchronous on rst=1): all synchronizer flops 0, pin_sync 0, pin_filt 0, cnt 0, rise_pulse 0, fall_pulse 0, chg_any 0.
- A pin held high through reset produces exactly one rise_pulse after release; this is intended.
- Reset asserted mid-count discards the count. No pulse is generated by reset itself.

## Timing
- pin_in to pin_sync: SYNC_STAGES rising edges.
- pin_sync first differs at edge k: pin_filt and the pulse are visible after edge k+T. Total pin_in to pin_filt latency is SYNC_STAGES+T cycles (3 for defaults, unfiltered).
- Minimum accepted pulse width on a filtered pin: T consecutive cycles at pin_sync. Width T-1 is rejected completely.
- Throughput: one event per pin every T cycles maximum.
- There are no combinational paths from any input to any output.

## Test plan
- Reset: drive pin_in=11'h7FF during rst. Outputs must be 0 while rst is high. After release, pin_sync=7FF after 2 cycles, pin_filt=7FF after 3 cycles, rise_pulse=7FF for exactly 1 cycle, chg_any=1 for 1 cycle.
- Unfiltered edge: filt_en=0. Toggle pin_in[3] 0->1->0 with 5-cycle hold. Require rise_pulse[3] 3 cycles after the rise, fall_pulse[3] 3 cycles after the fall, each 1 cycle wide.
- Glitch rejection: filt_en[0]=1, filt_len=4. A 3-cycle high pulse must produce no change. A 4-cycle high pulse must set pin_filt[0] at edge sync+4 with one rise_pulse[0].
- Chatter: filt_len=4, pattern 1,1,1,0,1,1,1,1 at pin_sync[5]. Require the counter to restart, and pin_filt[5] to rise only after the final 4 consecutive highs.
- Threshold change mid-count: filt_len=200, hold pin high 50 cycles, then set filt_len=10. Require an update on the next cycle. filt_len=0 must behave as 1.
- Simultaneous events: all 11 pins toggle together with mixed filt_en. Require correct per-pin latencies, a single chg_any per update cycle, and no cross-pin interference. Assert rst mid-count and verify outputs clear immediately.

Source files
------------

// File: rtl/evo_pin_filter_if.sv
// Pin-conditioning bus: raw pin levels and filter controls in, conditioned levels and
// edge events out.
interface evo_pin_filter_if #(
    parameter int WIDTH      = 11,
    parameter int FILT_CNT_W = 8
);
    logic [WIDTH-1:0]      pin_in;
    logic [WIDTH-1:0]      filt_en;
    logic [FILT_CNT_W-1:0] filt_len;
    logic [WIDTH-1:0]      pin_sync;
    logic [WIDTH-1:0]      pin_filt;
    logic [WIDTH-1:0]      rise_pulse;
    logic [WIDTH-1:0]      fall_pulse;
    logic                  chg_any;

    modport master (
        output pin_in, filt_en, filt_len,
        input  pin_sync, pin_filt, rise_pulse, fall_pulse, chg_any
    );

    modport slave (
        input  pin_in, filt_en, filt_len,
        output pin_sync, pin_filt, rise_pulse, fall_pulse, chg_any
    );
endinterface

// File: rtl/evo_pin_filter.sv
// Feather D-pin input conditioning: per-pin synchronizer, programmable glitch filter,
// and registered rise/fall event pulses for core peripherals.
module evo_pin_filter_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pin,
    input  logic                  i_en,
    input  logic [FILT_CNT_W-1:0] i_len,
    output logic                  o_sync,
    output logic                  o_filt,
    output logic                  o_rise,
    output logic                  o_fall,
    output logic                  o_upd
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_rise;
    logic                   r_fall;
    logic [FILT_CNT_W-1:0]  r_cnt;

    logic [FILT_CNT_W-1:0]  w_thr;
    logic [FILT_CNT_W:0]    w_nxt;
    logic                   w_sync;
    logic                   w_diff;
    logic                   w_upd;

    // A disabled filter or zero length both collapse to a one-cycle threshold.
    always_comb begin
        w_sync = r_sync[SYNC_STAGES-1];
        w_thr  = (!i_en || i_len == '0) ? FILT_CNT_W'(1) : i_len;
        w_nxt  = {1'b0, r_cnt} + (FILT_CNT_W+1)'(1);
        w_diff = w_sync ^ r_filt;
        // >= so that a lowered threshold fires on the next differing cycle.
        w_upd  = w_diff && (w_nxt >= {1'b0, w_thr});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_filt <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_rise <= w_upd & w_sync;
            r_fall <= w_upd & ~w_sync;
            if (!w_diff || w_upd)
                r_cnt <= '0;
            else
                r_cnt <= w_nxt[FILT_CNT_W-1:0];
            if (w_upd)
                r_filt <= w_sync;
        end
    end

    assign o_sync = w_sync;
    assign o_filt = r_filt;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_upd  = w_upd;
endmodule

module evo_pin_filter #(
    parameter int WIDTH       = 11,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CNT_W  = 8
) (
    input logic                  clk,
    input logic                  rst,
    evo_pin_filter_if.slave      bus
);
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_upd;
    logic             r_chg_any;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        evo_pin_filter_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CNT_W  (FILT_CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_pin  (bus.pin_in[gi]),
            .i_en   (bus.filt_en[gi]),
            .i_len  (bus.filt_len),
            .o_sync (w_sync[gi]),
            .o_filt (w_filt[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi]),
            .o_upd  (w_upd[gi])
        );
    end

    // Every update produces exactly one rise or fall, so OR of updates is the next chg_any.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chg_any <= 1'b0;
        else
            r_chg_any <= |w_upd;
    end

    assign bus.pin_sync   = w_sync;
    assign bus.pin_filt   = w_filt;
    assign bus.rise_pulse = w_rise;
    assign bus.fall_pulse = w_fall;
    assign bus.chg_any    = r_chg_any;
endmodule

// File: tb/tb_evo_pin_filter.sv
// Directed bench for evo_pin_filter: cycle table for reset/unfiltered/glitch cases,
// hand sequences for chatter, threshold change, simultaneous events and mid-count reset.
module tb_evo_pin_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    evo_pin_filter_if #(.WIDTH(11), .FILT_CNT_W(8)) bus ();

    evo_pin_filter #(.WIDTH(11), .SYNC_STAGES(2), .FILT_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [10:0] pin;
        logic [10:0] en;
        logic [7:0]  len;
        logic [10:0] sync;
        logic [10:0] filt;
        logic [10:0] rise;
        logic [10:0] fall;
        logic        chg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] pin, input logic [10:0] en, input logic [7:0] len);
        bus.pin_in   = pin;
        bus.filt_en  = en;
        bus.filt_len = len;
    endtask

    task automatic idle(input int n);
        drive(11'h000, 11'h000, 8'd0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        drive(11'h7FF, 11'h000, 8'd0);
        // rst, pin, en, len | sync, filt, rise, fall, chg
        tbl.push_back('{1'b1, 11'h7FF, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b1, 11'h7FF, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h7FF, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h7FF, 11'h000, 8'd0, 11'h7FF, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h7FF, 11'h000, 8'd0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h000, 1'b1});
        tbl.push_back('{1'b0, 11'h7FF, 11'h000, 8'd0, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h000, 11'h7FF, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h7FF, 1'b1});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        // unfiltered pin 3, 5-cycle high
        tbl.push_back('{1'b0, 11'h008, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h008, 11'h000, 8'd0, 11'h008, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h008, 11'h000, 8'd0, 11'h008, 11'h008, 11'h008, 11'h000, 1'b1});
        tbl.push_back('{1'b0, 11'h008, 11'h000, 8'd0, 11'h008, 11'h008, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h008, 11'h000, 8'd0, 11'h008, 11'h008, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h008, 11'h008, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h000, 11'h008, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h008, 1'b1});
        tbl.push_back('{1'b0, 11'h000, 11'h000, 8'd0, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        // filtered pin 0, len 4: 3-cycle pulse rejected
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        // 4-cycle pulse accepted, then 4-cycle low accepted
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h001, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h001, 11'h000, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h001, 11'h001, 11'h000, 1'b1});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h001, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h001, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h001, 11'h000, 11'h000, 1'b0});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h000, 11'h000, 11'h001, 1'b1});
        tbl.push_back('{1'b0, 11'h000, 11'h001, 8'd4, 11'h000, 11'h000, 11'h000, 11'h000, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].pin, tbl[i].en, tbl[i].len);
            tick();
            chk($sformatf("row%0d sync", i), 32'(bus.pin_sync),   32'(tbl[i].sync));
            chk($sformatf("row%0d filt", i), 32'(bus.pin_filt),   32'(tbl[i].filt));
            chk($sformatf("row%0d rise", i), 32'(bus.rise_pulse), 32'(tbl[i].rise));
            chk($sformatf("row%0d fall", i), 32'(bus.fall_pulse), 32'(tbl[i].fall));
            chk($sformatf("row%0d chg", i),  32'(bus.chg_any),    32'(tbl[i].chg));
        end

        // Chatter on pin 5: a single low in the run restarts the count.
        begin
            logic [7:0] pat;
            pat = 8'b1111_0111;  // bit j = pattern element j+1 (1,1,1,0,1,1,1,1)
            for (int c = 1; c <= 12; c++) begin
                drive((c <= 8) ? {5'b0, pat[c-1], 5'b0} : 11'h020, 11'h020, 8'd4);
                tick();
                chk($sformatf("chatter c%0d rise5", c), 32'(bus.rise_pulse[5]), 32'(c == 10));
                chk($sformatf("chatter c%0d filt5", c), 32'(bus.pin_filt[5]),   32'(c >= 10));
            end
            idle(10);
        end

        // Threshold lowered mid-count fires on the next cycle.
        for (int c = 1; c <= 52; c++) begin
            drive(11'h080, 11'h080, 8'd200);
            tick();
        end
        chk("thr hold filt7", 32'(bus.pin_filt[7]), 32'd0);
        drive(11'h080, 11'h080, 8'd10);
        tick();
        chk("thr drop rise7", 32'(bus.rise_pulse[7]), 32'd1);
        chk("thr drop filt7", 32'(bus.pin_filt[7]),   32'd1);
        chk("thr drop chg",   32'(bus.chg_any),       32'd1);
        tick();
        chk("thr after rise7", 32'(bus.rise_pulse[7]), 32'd0);

        // filt_len 0 with filter enabled behaves as T=1.
        drive(11'h000, 11'h080, 8'd0);
        tick();
        tick();
        chk("len0 c2 fall7", 32'(bus.fall_pulse[7]), 32'd0);
        tick();
        chk("len0 c3 fall7", 32'(bus.fall_pulse[7]), 32'd1);
        chk("len0 c3 filt7", 32'(bus.pin_filt[7]),   32'd0);
        idle(4);

        // All pins together, even pins filtered at T=3, odd pins unfiltered.
        for (int c = 1; c <= 6; c++) begin
            drive(11'h7FF, 11'h555, 8'd3);
            tick();
            chk($sformatf("sim c%0d rise", c), 32'(bus.rise_pulse),
                (c == 3) ? 32'h2AA : (c == 5) ? 32'h555 : 32'h0);
            chk($sformatf("sim c%0d filt", c), 32'(bus.pin_filt),
                (c >= 5) ? 32'h7FF : (c >= 3) ? 32'h2AA : 32'h0);
            chk($sformatf("sim c%0d chg", c), 32'(bus.chg_any), 32'(c == 3 || c == 5));
            chk($sformatf("sim c%0d fall", c), 32'(bus.fall_pulse), 32'h0);
        end

        // Fall begins; reset lands while the filtered pins are mid-count.
        for (int c = 1; c <= 4; c++) begin
            drive(11'h000, 11'h555, 8'd3);
            tick();
        end
        chk("pre-rst filt", 32'(bus.pin_filt), 32'h555);
        #2 rst = 1'b1;
        #1;
        chk("async rst filt", 32'(bus.pin_filt),   32'h0);
        chk("async rst sync", 32'(bus.pin_sync),   32'h0);
        chk("async rst rise", 32'(bus.rise_pulse), 32'h0);
        chk("async rst fall", 32'(bus.fall_pulse), 32'h0);
        chk("async rst chg",  32'(bus.chg_any),    32'h0);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("post-rst c%0d pulses", c),
                32'(bus.rise_pulse | bus.fall_pulse), 32'h0);
            chk($sformatf("post-rst c%0d chg", c),  32'(bus.chg_any),  32'h0);
            chk($sformatf("post-rst c%0d filt", c), 32'(bus.pin_filt), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
